// File: rtl/percept_pkg.sv
// Shared widths, frame length and state encoding for the percept serial link.
// Optional feature macro: PERCEPT_TX_PARITY_EN (appends an even-parity bit).
package percept_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 62;

`ifdef PERCEPT_TX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    // Start bit plus all fields (and parity when enabled).
    localparam int unsigned FRAME_LEN = 1 + ADDR_W + OP_W + DATA_W + PAR_W;
    // Bits held in the shift register: everything after the start bit.
    localparam int unsigned SHIFT_W   = FRAME_LEN - 1;
    localparam int unsigned CNT_W     = 7;
    localparam int unsigned GAP_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] data;
    } tx_req_t;

    // Build the post-start-bit payload in transmit order, MSB first.
    function automatic logic [SHIFT_W-1:0] pack_payload(input tx_req_t req);
`ifdef PERCEPT_TX_PARITY_EN
        return {req, ^req};
`else
        return req;
`endif
    endfunction

endpackage

// File: rtl/percept_frame_tx.sv
// Serial frame transmitter: start bit 0, address, opcode, data, MSB first,
// followed by GAP_CYCLES forced idle-high cycles.
// Optional feature macro: PERCEPT_TX_PARITY_EN (even parity after data[0]).
module percept_frame_tx
    import percept_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME_LEN - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    tx_state_e          state_q, state_nx;
    logic [SHIFT_W-1:0] sh_q, sh_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic [GAP_W-1:0]   gap_q, gap_nx;
    logic               tx_nx;
    logic               ready_nx;
    logic               busy_nx;
    logic               done_nx;
    tx_req_t            req;

    assign req = '{address: address, opcode: opcode, data: data};

    // Next-state and next-output logic; tx is registered so bit k lands k+1 cycles after acceptance.
    always_comb begin
        state_nx = state_q;
        sh_nx    = sh_q;
        cnt_nx   = cnt_q;
        gap_nx   = gap_q;
        tx_nx    = 1'b1;
        done_nx  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nx = SEND;
                    sh_nx    = pack_payload(req);
                    cnt_nx   = '0;
                    tx_nx    = 1'b0;
                end
            end
            SEND: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_nx   = '0;
                    gap_nx   = '0;
                    state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    tx_nx   = sh_q[SHIFT_W-1];
                    sh_nx   = {sh_q[SHIFT_W-2:0], 1'b1};
                    cnt_nx  = cnt_q + CNT_W'(1);
                    done_nx = (cnt_q == PRE_LAST);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        ready_nx = (state_nx == IDLE);
        busy_nx  = (state_nx != IDLE);
    end

    // State and output registers; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '1;
            cnt_q      <= '0;
            gap_q      <= '0;
            tx         <= 1'b1;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_nx;
            sh_q       <= sh_nx;
            cnt_q      <= cnt_nx;
            gap_q      <= gap_nx;
            tx         <= tx_nx;
            in_ready   <= ready_nx;
            busy       <= busy_nx;
            frame_done <= done_nx;
        end
    end

endmodule

// File: tb/tb_percept_frame_tx.sv
// Directed self-checking bench for percept_frame_tx (GAP_CYCLES = 2).
// Honours PERCEPT_TX_PARITY_EN for the expected frame length and parity bit.
module tb_percept_frame_tx;

`ifdef PERCEPT_TX_PARITY_EN
    localparam int FL = 75;
`else
    localparam int FL = 74;
`endif
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  address;
    logic [2:0]  opcode;
    logic [61:0] data;
    logic        tx;
    logic        busy;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    percept_frame_tx #(.GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .address    (address),
        .opcode     (opcode),
        .data       (data),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Send one frame, check every bit, deserialize it, then check gap and idle.
    task automatic run_frame(input logic [7:0] a, input logic [2:0] o, input logic [61:0] d,
                             input bit scramble, output logic last_bit);
        logic [FL-1:0] exp;
        logic          bits [FL];
        logic [7:0]    ra;
        logic [2:0]    ro;
`ifdef PERCEPT_TX_PARITY_EN
        exp = {1'b0, a, o, d, ^{a, o, d}};
`else
        exp = {1'b0, a, o, d};
`endif
        address  = a;
        opcode   = o;
        data     = d;
        in_valid = 1'b1;
        chk("pre_ready", 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
        bits[0] = tx;
        chk("start_bit", 32'(tx), 32'd0);
        chk("busy_send", 32'(busy), 32'd1);
        chk("ready_send", 32'(in_ready), 32'd0);
        for (int k = 1; k < FL; k++) begin
            if (scramble && k == 5) begin
                address  = ~a;
                opcode   = ~o;
                data     = ~d;
                in_valid = 1'b1;
            end
            if (scramble && k == FL - 1) in_valid = 1'b0;
            step;
            bits[k] = tx;
            chk("frame_bit", 32'(tx), 32'(exp[FL-1-k]));
            chk("frame_done", 32'(frame_done), 32'(k == FL - 1));
        end
        for (int i = 0; i < 8; i++) ra[7-i] = bits[1+i];
        for (int i = 0; i < 3; i++) ro[2-i] = bits[9+i];
        chk("rx_addr", 32'(ra), 32'(a));
        chk("rx_opcode", 32'(ro), 32'(o));
        last_bit = bits[FL-1];
        for (int g = 0; g < GAP; g++) begin
            step;
            chk("gap_tx", 32'(tx), 32'd1);
            chk("gap_busy", 32'(busy), 32'd1);
            chk("gap_ready", 32'(in_ready), 32'd0);
            chk("gap_done", 32'(frame_done), 32'd0);
        end
        step;
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx", 32'(tx), 32'd1);
    endtask

    initial begin
        logic lb;
        int   cyc;
        int   acc0;
        int   acc1;
        bit   seen_done;

        // Reset with a simultaneous request: the request must not be taken.
        rst      = 1'b1;
        in_valid = 1'b1;
        address  = 8'h55;
        opcode   = 3'd1;
        data     = 62'h1;
        step;
        step;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        step;
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Reference frame AA / 4 / 100, with inputs scrambled during SEND.
        run_frame(8'hAA, 3'd4, 62'd100, 1'b1, lb);
        chk("aa_last_bit", 32'(lb), 32'd0);

        // Back-to-back requests: acceptance spacing and idle-high gap.
        address  = 8'h3C;
        opcode   = 3'd5;
        data     = 62'h2AAA_5555_0F0F_1234;
        in_valid = 1'b1;
        cyc  = 0;
        acc0 = -1;
        acc1 = -1;
        while (acc1 < 0 && cyc < 400) begin
            if (acc0 >= 0 && (cyc - acc0) > FL && (cyc - acc0) <= FL + GAP)
                chk("stream_gap_tx", 32'(tx), 32'd1);
            if (in_ready && in_valid) begin
                if (acc0 < 0) acc0 = cyc;
                else          acc1 = cyc;
            end
            step;
            cyc++;
        end
        in_valid = 1'b0;
        chk("accept_spacing", 32'(acc1 - acc0), 32'(FL + GAP + 1));
        cyc = 0;
        while (busy && cyc < 200) begin
            step;
            cyc++;
        end
        chk("stream_drain", 32'(busy), 32'd0);

        // Abort at bit 30 with reset.
        address  = 8'hF0;
        opcode   = 3'd2;
        data     = 62'h0;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        for (int k = 1; k <= 30; k++) step;
        chk("abort_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        seen_done = 1'b0;
        repeat (FL + 5) begin
            step;
            if (frame_done !== 1'b0 || tx !== 1'b1) seen_done = 1'b1;
        end
        chk("abort_quiet", 32'(seen_done), 32'd0);

        // Single set address bit: last bit is parity 1 when enabled, else data[0] = 0.
        run_frame(8'h01, 3'd0, 62'd0, 1'b0, lb);
`ifdef PERCEPT_TX_PARITY_EN
        chk("parity_bit", 32'(lb), 32'd1);
`else
        chk("last_data_bit", 32'(lb), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
